// File: rtl/pupil_detect_pkg.sv
// Shared constants, scan-state types and the pupil-pixel classifier for pupil_detect.
// Define PUPIL_DARK_EN for non-inverted sensors, where a dark pupil gives a low code.
package pupil_detect_pkg;

  localparam int MAX_RESOLUTION = 112;
  localparam int PIXEL_W        = 8;
  localparam int ROW_W          = MAX_RESOLUTION * PIXEL_W;
  localparam int IDX_W          = 7;
  localparam int LEN_W          = 7;

  localparam logic [PIXEL_W-1:0] PUPIL_THRESHOLD = 8'hC0;
  localparam logic [IDX_W-1:0]   LAST_IDX        = IDX_W'(MAX_RESOLUTION - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FINAL = 2'd2
  } scan_state_e;

  // Whole scan FSM state in one struct so it can be probed as a unit.
  typedef struct packed {
    scan_state_e           state;
    logic [IDX_W-1:0]      idx;
  } scan_state_t;

  function automatic logic is_pupil(input logic [PIXEL_W-1:0] px);
`ifdef PUPIL_DARK_EN
    return (px < PUPIL_THRESHOLD);
`else
    return (px >= PUPIL_THRESHOLD);
`endif
  endfunction

endpackage

// File: rtl/pupil_run_scanner.sv
// Finds the longest contiguous run of pupil pixels in one row, fed one pixel per cycle.
// Strobes: pix_valid_i qualifies a pixel; pix_start_i marks pixel 0, pix_last_i the final pixel.
module pupil_run_scanner
  import pupil_detect_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_valid_i,
  input  logic               pix_start_i,
  input  logic               pix_last_i,
  input  logic [IDX_W-1:0]   pix_idx_i,
  input  logic [PIXEL_W-1:0] pix_i,
  output logic [IDX_W-1:0]   best_start_o,
  output logic [LEN_W-1:0]   best_len_o
);

  logic [IDX_W-1:0] cur_start_q, cur_start_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [IDX_W-1:0] best_start_q, best_start_d;
  logic [LEN_W-1:0] best_len_q, best_len_d;

  logic [LEN_W-1:0] cur_len_eff, best_len_eff, new_len, cand_len;
  logic [IDX_W-1:0] best_start_eff, new_start, cand_start;
  logic             pupil, close_run;

  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;

    // Pixel 0 sees an empty history regardless of what the previous row left behind.
    cur_len_eff    = pix_start_i ? '0 : cur_len_q;
    best_len_eff   = pix_start_i ? '0 : best_len_q;
    best_start_eff = pix_start_i ? '0 : best_start_q;

    pupil     = is_pupil(pix_i);
    new_len   = '0;
    new_start = cur_start_q;
    if (pupil) begin
      new_len   = cur_len_eff + 1'b1;
      new_start = (cur_len_eff == '0) ? pix_idx_i : cur_start_q;
    end
    cand_len   = pupil ? new_len : cur_len_eff;
    cand_start = pupil ? new_start : cur_start_q;
    close_run  = !pupil || pix_last_i;

    if (pix_valid_i) begin
      cur_start_d  = new_start;
      cur_len_d    = new_len;
      best_start_d = best_start_eff;
      best_len_d   = best_len_eff;
      // Strictly greater: on a tie the earlier run stays.
      if (close_run && (cand_len > best_len_eff)) begin
        best_start_d = cand_start;
        best_len_d   = cand_len;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/pupil_detect.sv
// Streaming pupil locator: detects a new row, scans it for the widest pupil run and
// keeps the frame's widest row (vertical) and that run's centre column (horizontal).
module pupil_detect
  import pupil_detect_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [ROW_W-1:0] img_buf_newline,
  input  logic             frame_capture_done,
  output logic [7:0]       pupil_location_horizontal,
  output logic [7:0]       pupil_location_vertical
);

  logic [ROW_W-1:0] shadow_q, shadow_d;
  scan_state_t      scan_q, scan_d;
  logic [7:0]       row_cnt_q, row_cnt_d;
  logic [7:0]       best_w_q, best_w_d;
  logic [7:0]       horiz_q, horiz_d;
  logic [7:0]       vert_q, vert_d;

  logic               pix_valid, pix_start, pix_last;
  logic [PIXEL_W-1:0] pix;
  logic [IDX_W-1:0]   run_start;
  logic [LEN_W-1:0]   run_len;
  logic [7:0]         run_len8;

  assign pix      = shadow_q[scan_q.idx * PIXEL_W +: PIXEL_W];
  assign run_len8 = {1'b0, run_len};

  always_comb begin
    shadow_d  = shadow_q;
    scan_d    = scan_q;
    row_cnt_d = row_cnt_q;
    best_w_d  = best_w_q;
    horiz_d   = horiz_q;
    vert_d    = vert_q;
    pix_valid = 1'b0;
    pix_start = 1'b0;
    pix_last  = 1'b0;

    if (frame_capture_done) begin
      // Between frames: forget per-frame tracking, but outputs keep their last value.
      scan_d.state = ST_IDLE;
      scan_d.idx   = '0;
      row_cnt_d    = '0;
      best_w_d     = '0;
    end else if (img_buf_newline != shadow_q) begin
      shadow_d     = img_buf_newline;
      scan_d.state = ST_SCAN;
      scan_d.idx   = '0;
    end else begin
      unique case (scan_q.state)
        ST_SCAN: begin
          pix_valid = 1'b1;
          pix_start = (scan_q.idx == '0);
          pix_last  = (scan_q.idx == LAST_IDX);
          if (pix_last) begin
            scan_d.state = ST_FINAL;
            scan_d.idx   = '0;
          end else begin
            scan_d.idx = scan_q.idx + 1'b1;
          end
        end
        ST_FINAL: begin
          scan_d.state = ST_IDLE;
          if (run_len8 > best_w_q) begin
            best_w_d = run_len8;
            vert_d   = row_cnt_q;
            horiz_d  = {1'b0, run_start} + ((run_len8 - 8'd1) >> 1);
          end
          row_cnt_d = (row_cnt_q == 8'hFF) ? row_cnt_q : row_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q  <= '0;
      scan_q    <= '{state: ST_IDLE, idx: '0};
      row_cnt_q <= '0;
      best_w_q  <= '0;
      horiz_q   <= '0;
      vert_q    <= '0;
    end else begin
      shadow_q  <= shadow_d;
      scan_q    <= scan_d;
      row_cnt_q <= row_cnt_d;
      best_w_q  <= best_w_d;
      horiz_q   <= horiz_d;
      vert_q    <= vert_d;
    end
  end

  pupil_run_scanner u_scanner (
    .clock        (clock),
    .reset        (reset),
    .pix_valid_i  (pix_valid),
    .pix_start_i  (pix_start),
    .pix_last_i   (pix_last),
    .pix_idx_i    (scan_q.idx),
    .pix_i        (pix),
    .best_start_o (run_start),
    .best_len_o   (run_len)
  );

  assign pupil_location_horizontal = horiz_q;
  assign pupil_location_vertical   = vert_q;

endmodule

// File: tb/tb_pupil_detect.sv
// Directed bench for pupil_detect: rows are held for one 114-cycle line period and the
// outputs are compared against hand-computed row/centre values.
module tb_pupil_detect;
  import pupil_detect_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic [ROW_W-1:0] img;
  logic             done;
  logic [7:0]       h_out;
  logic [7:0]       v_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pupil_detect dut (
    .clock                     (clock),
    .reset                     (reset),
    .img_buf_newline           (img),
    .frame_capture_done        (done),
    .pupil_location_horizontal (h_out),
    .pupil_location_vertical   (v_out)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] fill_row(input logic [7:0] bg);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < MAX_RESOLUTION; i++) r[i*8 +: 8] = bg;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] add_run(input logic [ROW_W-1:0] r_in, input int s,
                                               input int e, input logic [7:0] val);
    logic [ROW_W-1:0] r;
    r = r_in;
    for (int i = s; i <= e; i++) r[i*8 +: 8] = val;
    return r;
  endfunction

  // Drive at a negedge, hold one full line period, return at the following negedge.
  task automatic present_row(input logic [ROW_W-1:0] r);
    img = r;
    repeat (114) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [ROW_W-1:0] row;

  initial begin
    reset = 1'b1;
    done  = 1'b1;
    img   = '0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check8("reset_h", h_out, 8'd0);
    check8("reset_v", v_out, 8'd0);
    reset = 1'b0;
    done  = 1'b0;

    // Frame 1: background 7F, widest run on row 1 (31..80).
    present_row(add_run(fill_row(8'h7F), 50, 61, 8'hFF));
    check8("f1_r0_v", v_out, 8'd0);
    check8("f1_r0_h", h_out, 8'd55);
    present_row(add_run(fill_row(8'h7F), 31, 80, 8'hFF));
    check8("f1_r1_v", v_out, 8'd1);
    check8("f1_r1_h", h_out, 8'd55);
    present_row(add_run(fill_row(8'h7F), 37, 74, 8'hFF));
    present_row(add_run(fill_row(8'h7F), 43, 67, 8'hFF));
    present_row(add_run(fill_row(8'h7F), 50, 61, 8'hFF));
    check8("f1_r4_v", v_out, 8'd1);
    check8("f1_r4_h", h_out, 8'd55);

    // Frame 2: background 0, threshold-edge pixels around the runs.
    pulse_reset();
    present_row(add_run(fill_row(8'h00), 62, 73, 8'hFF));
    check8("f2_r0_v", v_out, 8'd0);
    check8("f2_r0_h", h_out, 8'd67);
    present_row(add_run(fill_row(8'h00), 56, 80, 8'hFF));
    row = add_run(fill_row(8'h00), 49, 86, 8'hFF);
    row = add_run(row, 48, 48, 8'h80);
    row = add_run(row, 87, 87, 8'h7F);
    present_row(row);
    check8("f2_r2_v", v_out, 8'd2);
    check8("f2_r2_h", h_out, 8'd67);
    row = add_run(fill_row(8'h00), 44, 92, 8'hFF);
    row = add_run(row, 43, 43, 8'h80);
    row = add_run(row, 92, 92, 8'hC0);
    row = add_run(row, 93, 93, 8'h7F);
    present_row(row);
    check8("f2_r3_v", v_out, 8'd3);
    check8("f2_r3_h", h_out, 8'd68);
    present_row(add_run(fill_row(8'h00), 49, 86, 8'hFF));
    present_row(add_run(fill_row(8'h00), 56, 80, 8'hFF));
    present_row(add_run(fill_row(8'h00), 62, 73, 8'hFF));
    check8("f2_r6_v", v_out, 8'd3);
    check8("f2_r6_h", h_out, 8'd68);

    // Reset in the middle of a scan of a very wide row.
    img = add_run(fill_row(8'h00), 5, 104, 8'hFF);
    repeat (40) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check8("midscan_rst_h", h_out, 8'd0);
    check8("midscan_rst_v", v_out, 8'd0);
    reset = 1'b0;

    // Row bus changes twice in two cycles: only the final row is counted.
    img = fill_row(8'h7F);
    @(negedge clock);
    present_row(add_run(fill_row(8'h7F), 10, 29, 8'hFF));
    check8("dbl_r0_v", v_out, 8'd0);
    check8("dbl_r0_h", h_out, 8'd19);
    present_row(add_run(fill_row(8'h7F), 0, 29, 8'hFF));
    check8("first_px_v", v_out, 8'd1);
    check8("first_px_h", h_out, 8'd14);
    present_row(add_run(fill_row(8'h7F), 72, 111, 8'hFF));
    check8("last_px_v", v_out, 8'd2);
    check8("last_px_h", h_out, 8'd91);

    // Ties: row 2 holds two width-20 runs, row 5 repeats width 20.
    pulse_reset();
    present_row(add_run(fill_row(8'h7F), 0, 4, 8'hFF));
    check8("tie_r0_v", v_out, 8'd0);
    check8("tie_r0_h", h_out, 8'd2);
    present_row(add_run(fill_row(8'h7F), 20, 29, 8'hFF));
    present_row(add_run(add_run(fill_row(8'h7F), 0, 19, 8'hFF), 50, 69, 8'hFF));
    check8("tie_r2_v", v_out, 8'd2);
    check8("tie_r2_h", h_out, 8'd9);
    present_row(add_run(fill_row(8'h7F), 40, 54, 8'hFF));
    present_row(fill_row(8'h7F));
    present_row(add_run(fill_row(8'h7F), 80, 99, 8'hFF));
    check8("tie_r5_v", v_out, 8'd2);
    check8("tie_r5_h", h_out, 8'd9);

    // Frame boundary mid-frame: counters restart, outputs hold until a wider run.
    done = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check8("done_hold_v", v_out, 8'd2);
    check8("done_hold_h", h_out, 8'd9);
    done = 1'b0;
    present_row(fill_row(8'h7F));
    check8("empty_row_v", v_out, 8'd2);
    check8("empty_row_h", h_out, 8'd9);
    present_row(add_run(fill_row(8'h7F), 100, 104, 8'hFF));
    check8("after_done_v", v_out, 8'd1);
    check8("after_done_h", h_out, 8'd102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
